// File: rtl/mips_pkg.sv
// Shared register-file definitions for the writeback path.
package mips_pkg;

    localparam int unsigned REG_AW    = 5;
    localparam int unsigned REG_DW    = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

    // One-hot register select used by the pending scoreboard.
    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_AW-1:0] a);
        return REG_COUNT'(1) << a;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for MDU writeback requests; full/empty derive from the registered count.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_push,
    input  wb_req_t i_data,
    input  logic    i_pop,
    output wb_req_t o_data,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == CW'(0));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port master: ALU results take priority over buffered MDU results,
// with a pending scoreboard for outstanding MDU destinations.
module writeback_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = REG_AW,
    parameter int unsigned DW    = REG_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_wb_valid,
    input  logic [AW-1:0]        alu_wb_addr,
    input  logic [DW-1:0]        alu_wb_data,
    input  logic                 mdu_wb_valid,
    output logic                 mdu_wb_ready,
    input  logic [AW-1:0]        mdu_wb_addr,
    input  logic [DW-1:0]        mdu_wb_data,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_addr,
    output logic                 issue_ready,
    output logic                 alu_stall,
    output logic [REG_COUNT-1:0] pending_mask,
    output logic                 waw_err,
    output logic                 write_enable,
    output logic [AW-1:0]        write_addr,
    output logic [DW-1:0]        write_data
);

    wb_req_t                w_push_req;
    wb_req_t                w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_alu_nonzero;
    logic [REG_COUNT-1:0]   w_set_mask;
    logic [REG_COUNT-1:0]   w_clr_mask;
    logic [REG_COUNT-1:0]   w_pending_next;

    logic                   r_write_enable;
    logic [AW-1:0]          r_write_addr;
    logic [DW-1:0]          r_write_data;
    logic [REG_COUNT-1:0]   r_pending;
    logic                   r_waw_err;

    assign w_push_req.addr = REG_AW'(mdu_wb_addr);
    assign w_push_req.data = REG_DW'(mdu_wb_data);

    assign mdu_wb_ready  = !w_fifo_full;
    assign alu_stall     = w_fifo_full;
    assign issue_ready   = !r_pending[issue_addr];
    assign w_push        = mdu_wb_valid && !w_fifo_full;
    assign w_pop         = !alu_wb_valid && !w_fifo_empty;
    assign w_alu_nonzero = (REG_AW'(alu_wb_addr) != REG_ZERO);

    wb_fifo #(
        .DEPTH   (DEPTH)
    ) u_mdu_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Scoreboard: a FIFO-sourced write clears its bit, a same-cycle issue re-sets it; r0 never pends.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (issue_valid && (REG_AW'(issue_addr) != REG_ZERO)) begin
            w_set_mask = reg_onehot(REG_AW'(issue_addr));
        end
        if (w_pop && (w_head.addr != REG_ZERO)) begin
            w_clr_mask = reg_onehot(w_head.addr);
        end
        w_pending_next    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_next[0] = 1'b0;
    end

    // Write-port register: ALU first, then FIFO head; addr/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_enable <= 1'b0;
            r_write_addr   <= '0;
            r_write_data   <= '0;
            r_pending      <= '0;
            r_waw_err      <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_waw_err <= alu_wb_valid && w_alu_nonzero && r_pending[alu_wb_addr];
            if (alu_wb_valid) begin
                r_write_enable <= w_alu_nonzero;
                r_write_addr   <= alu_wb_addr;
                r_write_data   <= alu_wb_data;
            end else if (w_pop) begin
                r_write_enable <= (w_head.addr != REG_ZERO);
                r_write_addr   <= AW'(w_head.addr);
                r_write_data   <= DW'(w_head.data);
            end else begin
                r_write_enable <= 1'b0;
            end
        end
    end

    assign write_enable = r_write_enable;
    assign write_addr   = r_write_addr;
    assign write_data   = r_write_data;
    assign pending_mask = r_pending;
    assign waw_err      = r_waw_err;

endmodule
